// File: rtl/gecko_decode_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : gecko_decode_scoreboard
// Description : Decode-stage register scoreboard. Each architectural register
//               (except r0, hardwired zero) has a saturating pending-write
//               counter. Issue is allowed when every source operand is idle
//               or can be taken from the execute forward register, and the
//               destination counter has headroom. Writebacks retire pending
//               writes on several independent ports.
//
//               Ports
//                 clk, rst           : clock, synchronous active-high reset
//                 issue_valid/ready  : issue handshake (accept = both high)
//                 issue_rd/rs1/rs2   : destination and source register ids
//                 issue_use_rs1/rs2  : source operand is actually read
//                 issue_writes_rd    : op writes its destination
//                 issue_forwardable  : op result lands in the forward register
//                 retire_valid/rd    : writeback completions, port i at
//                                      retire_rd[i*ADDR_W +: ADDR_W]
//                 rs1/rs2_forward    : operand comes from the forward register
//                 busy_mask          : bit r set while register r is pending
//                 empty              : no register pending
//                 error              : sticky retire-underflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module gecko_decode_scoreboard #(
    parameter int NUM_REGS         = 32,
    parameter int COUNTER_WIDTH    = 2,
    parameter int NUM_RETIRE_PORTS = 2,
    localparam int ADDR_W          = $clog2(NUM_REGS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             issue_valid,
    output logic                             issue_ready,
    input  logic [ADDR_W-1:0]                issue_rd,
    input  logic [ADDR_W-1:0]                issue_rs1,
    input  logic [ADDR_W-1:0]                issue_rs2,
    input  logic                             issue_use_rs1,
    input  logic                             issue_use_rs2,
    input  logic                             issue_writes_rd,
    input  logic                             issue_forwardable,
    input  logic [NUM_RETIRE_PORTS-1:0]      retire_valid,
    input  logic [NUM_RETIRE_PORTS*ADDR_W-1:0] retire_rd,
    output logic                             rs1_forward,
    output logic                             rs2_forward,
    output logic [NUM_REGS-1:0]              busy_mask,
    output logic                             empty,
    output logic                             error
);

    // Width able to hold the number of retire ports hitting one register.
    localparam int c_DEC_W = $clog2(NUM_RETIRE_PORTS + 1);
    // Width for "counter + one issue" compared against the retire count.
    localparam int c_SUM_W = COUNTER_WIDTH + c_DEC_W + 1;
    localparam logic [COUNTER_WIDTH-1:0] c_CNT_MAX = '1;

    logic [COUNTER_WIDTH-1:0] r_cnt [NUM_REGS];
    logic [ADDR_W-1:0]        r_fwd_reg;
    logic                     r_error;

    // State as seen by the combinational outputs. While rst is high the
    // registers may still hold stale (or unknown) values, so everything
    // visible is taken from the cleared state instead.
    logic [COUNTER_WIDTH-1:0] w_cnt [NUM_REGS];
    logic [ADDR_W-1:0]        w_fwd;

    logic [COUNTER_WIDTH-1:0] w_cnt_nxt [NUM_REGS];
    logic                     w_underflow;

    logic w_rs1_ok;
    logic w_rs2_ok;
    logic w_rd_ok;
    logic w_accept;
    logic w_inc_en;
    logic [NUM_REGS-1:0] w_busy;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            w_cnt[r] = rst ? '0 : r_cnt[r];
        end
        w_cnt[0] = '0;
    end

    assign w_fwd = rst ? '0 : r_fwd_reg;

    // ------------------------------------------------------------------
    // Issue readiness: current-cycle state only, retires in this cycle
    // do not free an operand until the next edge.
    // ------------------------------------------------------------------
    assign w_rs1_ok = !issue_use_rs1 || (issue_rs1 == '0) || (w_cnt[issue_rs1] == '0) ||
                      ((issue_rs1 == w_fwd) && (w_fwd != '0));
    assign w_rs2_ok = !issue_use_rs2 || (issue_rs2 == '0) || (w_cnt[issue_rs2] == '0) ||
                      ((issue_rs2 == w_fwd) && (w_fwd != '0));
    assign w_rd_ok  = !issue_writes_rd || (issue_rd == '0) || (w_cnt[issue_rd] != c_CNT_MAX);

    assign issue_ready = w_rs1_ok && w_rs2_ok && w_rd_ok;

    assign rs1_forward = issue_use_rs1 && (issue_rs1 != '0) && (issue_rs1 == w_fwd);
    assign rs2_forward = issue_use_rs2 && (issue_rs2 != '0) && (issue_rs2 == w_fwd);

    assign w_accept = issue_valid && issue_ready;
    assign w_inc_en = w_accept && issue_writes_rd && (issue_rd != '0);

    // ------------------------------------------------------------------
    // Counter next state: one net update per register combining the
    // issue increment with all retire decrements, clamped at zero.
    // ------------------------------------------------------------------
    always_comb begin
        logic [c_SUM_W-1:0] w_sum;
        logic [c_SUM_W-1:0] w_dec;
        w_underflow = 1'b0;
        w_sum       = '0;
        w_dec       = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_cnt_nxt[r] = '0;
        end
        for (int r = 1; r < NUM_REGS; r++) begin
            w_sum = c_SUM_W'(r_cnt[r]) +
                    c_SUM_W'(w_inc_en && (issue_rd == ADDR_W'(r)));
            w_dec = '0;
            for (int p = 0; p < NUM_RETIRE_PORTS; p++) begin
                if (retire_valid[p] && (retire_rd[p*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                    w_dec = w_dec + c_SUM_W'(1);
                end
            end
            if (w_dec > w_sum) begin
                w_cnt_nxt[r] = '0;
                w_underflow  = 1'b1;
            end else begin
                w_cnt_nxt[r] = COUNTER_WIDTH'(w_sum - w_dec);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= '0;
            end
            r_fwd_reg <= '0;
            r_error   <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= w_cnt_nxt[r];
            end
            r_error <= r_error | w_underflow;
            // A newer non-forwardable write to the tagged register makes the
            // forward register stale for that name; retires never touch it.
            if (w_inc_en) begin
                if (issue_forwardable) begin
                    r_fwd_reg <= issue_rd;
                end else if (issue_rd == r_fwd_reg) begin
                    r_fwd_reg <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_busy = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            w_busy[r] = (w_cnt[r] != '0);
        end
    end

    assign busy_mask = w_busy;
    assign empty     = ~|w_busy;
    assign error     = r_error & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_gecko_decode_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_gecko_decode_scoreboard
// Description : Self-checking bench for gecko_decode_scoreboard. Directed
//               scenarios plus randomized traffic compared every cycle with a
//               behavioural model (integer counters per register, net delta
//               per cycle, clamp at zero).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gecko_decode_scoreboard;

    localparam int c_NR   = 32;
    localparam int c_CW   = 2;
    localparam int c_NP   = 2;
    localparam int c_AW   = 5;
    localparam int c_MAXC = (1 << c_CW) - 1;

    logic              clk;
    logic              rst;
    logic              issue_valid;
    logic              issue_ready;
    logic [c_AW-1:0]   issue_rd;
    logic [c_AW-1:0]   issue_rs1;
    logic [c_AW-1:0]   issue_rs2;
    logic              issue_use_rs1;
    logic              issue_use_rs2;
    logic              issue_writes_rd;
    logic              issue_forwardable;
    logic [c_NP-1:0]   retire_valid;
    logic [c_NP*c_AW-1:0] retire_rd;
    logic              rs1_forward;
    logic              rs2_forward;
    logic [c_NR-1:0]   busy_mask;
    logic              empty;
    logic              error;

    gecko_decode_scoreboard #(
        .NUM_REGS        (c_NR),
        .COUNTER_WIDTH   (c_CW),
        .NUM_RETIRE_PORTS(c_NP)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .issue_valid      (issue_valid),
        .issue_ready      (issue_ready),
        .issue_rd         (issue_rd),
        .issue_rs1        (issue_rs1),
        .issue_rs2        (issue_rs2),
        .issue_use_rs1    (issue_use_rs1),
        .issue_use_rs2    (issue_use_rs2),
        .issue_writes_rd  (issue_writes_rd),
        .issue_forwardable(issue_forwardable),
        .retire_valid     (retire_valid),
        .retire_rd        (retire_rd),
        .rs1_forward      (rs1_forward),
        .rs2_forward      (rs2_forward),
        .busy_mask        (busy_mask),
        .empty            (empty),
        .error            (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    int m_cnt [c_NR];
    int m_fwd;
    bit m_err;

    // Observed outputs of the most recent cycle
    logic            obs_ready;
    logic            obs_f1;
    logic            obs_f2;
    logic [c_NR-1:0] obs_busy;
    logic            obs_empty;
    logic            obs_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, compare outputs with the model before
    // the edge, then advance the model across the edge.
    task automatic run_cycle(input bit rs, input bit v,
                             input int rd, input int rs1, input int rs2,
                             input bit u1, input bit u2, input bit wr, input bit fw,
                             input bit [1:0] rv, input int r0, input int r1);
        int  c1, c2, cd, fv, n;
        bit  ok1, ok2, okd, e_ready, e_f1, e_f2;
        logic [c_NR-1:0] e_busy;
        int  d [c_NR];
        @(negedge clk);
        rst               = rs;
        issue_valid       = v;
        issue_rd          = c_AW'(rd);
        issue_rs1         = c_AW'(rs1);
        issue_rs2         = c_AW'(rs2);
        issue_use_rs1     = u1;
        issue_use_rs2     = u2;
        issue_writes_rd   = wr;
        issue_forwardable = fw;
        retire_valid      = rv;
        retire_rd         = {c_AW'(r1), c_AW'(r0)};
        #1;
        c1  = rs ? 0 : m_cnt[rs1];
        c2  = rs ? 0 : m_cnt[rs2];
        cd  = rs ? 0 : m_cnt[rd];
        fv  = rs ? 0 : m_fwd;
        ok1 = !u1 || rs1 == 0 || c1 == 0 || (rs1 == fv && fv != 0);
        ok2 = !u2 || rs2 == 0 || c2 == 0 || (rs2 == fv && fv != 0);
        okd = !wr || rd == 0 || cd != c_MAXC;
        e_ready = ok1 && ok2 && okd;
        e_f1 = u1 && rs1 != 0 && rs1 == fv;
        e_f2 = u2 && rs2 != 0 && rs2 == fv;
        e_busy = '0;
        for (int r = 1; r < c_NR; r++) e_busy[r] = !rs && m_cnt[r] != 0;
        obs_ready = issue_ready;
        obs_f1    = rs1_forward;
        obs_f2    = rs2_forward;
        obs_busy  = busy_mask;
        obs_empty = empty;
        obs_err   = error;
        chk("issue_ready", 64'(issue_ready), 64'(e_ready));
        chk("rs1_forward", 64'(rs1_forward), 64'(e_f1));
        chk("rs2_forward", 64'(rs2_forward), 64'(e_f2));
        chk("busy_mask", 64'(busy_mask), 64'(e_busy));
        chk("empty", 64'(empty), 64'(e_busy == '0));
        chk("error", 64'(error), 64'(!rs && m_err));
        @(posedge clk);
        if (rs) begin
            for (int r = 0; r < c_NR; r++) m_cnt[r] = 0;
            m_fwd = 0;
            m_err = 0;
        end else begin
            for (int r = 0; r < c_NR; r++) d[r] = 0;
            if (v && e_ready && wr && rd != 0) begin
                d[rd]++;
                if (fw) m_fwd = rd;
                else if (rd == m_fwd) m_fwd = 0;
            end
            if (rv[0] && r0 != 0) d[r0]--;
            if (rv[1] && r1 != 0) d[r1]--;
            for (int r = 1; r < c_NR; r++) begin
                n = m_cnt[r] + d[r];
                if (n < 0) begin
                    n = 0;
                    m_err = 1;
                end
                m_cnt[r] = n;
            end
        end
    endtask

    task automatic do_reset();
        run_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    endtask

    task automatic do_issue(input int rd, input int rs1, input int rs2,
                            input bit u1, input bit u2, input bit wr, input bit fw);
        run_cycle(0, 1, rd, rs1, rs2, u1, u2, wr, fw, 2'b00, 0, 0);
    endtask

    task automatic do_read_retire(input int rs1, input bit [1:0] rv, input int r0, input int r1);
        run_cycle(0, 1, 0, rs1, 0, 1, 0, 0, 0, rv, r0, r1);
    endtask

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
        issue_use_rs1 = 1'b0; issue_use_rs2 = 1'b0; issue_writes_rd = 1'b0;
        issue_forwardable = 1'b0; retire_valid = '0; retire_rd = '0;
        for (int r = 0; r < c_NR; r++) m_cnt[r] = 0;
        m_fwd = 0;
        m_err = 0;

        // Reset state seen while rst is high
        do_reset();
        chk("rst_busy", 64'(obs_busy), 64'(0));
        chk("rst_empty", 64'(obs_empty), 64'(1));
        chk("rst_error", 64'(obs_err), 64'(0));
        chk("rst_ready", 64'(obs_ready), 64'(1));
        do_reset();

        // Pending write stalls a reader until retired, no same-cycle bypass
        do_issue(5, 0, 0, 0, 0, 1, 0);
        do_issue(0, 5, 0, 1, 0, 0, 0);
        chk("s1_stall", 64'(obs_ready), 64'(0));
        chk("s1_busy5", 64'(obs_busy[5]), 64'(1));
        do_read_retire(5, 2'b01, 5, 0);
        chk("s1_no_bypass", 64'(obs_ready), 64'(0));
        do_issue(0, 5, 0, 1, 0, 0, 0);
        chk("s1_ready", 64'(obs_ready), 64'(1));
        chk("s1_empty", 64'(obs_empty), 64'(1));

        // Forwardable producer feeds both operands next cycle
        do_reset();
        do_issue(7, 0, 0, 0, 0, 1, 1);
        do_issue(0, 7, 7, 1, 1, 0, 0);
        chk("s2_ready", 64'(obs_ready), 64'(1));
        chk("s2_f1", 64'(obs_f1), 64'(1));
        chk("s2_f2", 64'(obs_f2), 64'(1));

        // Counter saturation blocks a fourth writer
        do_reset();
        repeat (3) do_issue(3, 0, 0, 0, 0, 1, 0);
        do_issue(3, 0, 0, 0, 0, 1, 0);
        chk("s3_full", 64'(obs_ready), 64'(0));
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 3, 0);
        do_issue(3, 0, 0, 0, 0, 1, 0);
        chk("s3_room", 64'(obs_ready), 64'(1));

        // Issue and retire on one register cancel; dual retire removes two
        do_reset();
        do_issue(4, 0, 0, 0, 0, 1, 0);
        run_cycle(0, 1, 4, 0, 0, 0, 0, 1, 0, 2'b01, 4, 0);
        do_issue(4, 0, 0, 0, 0, 1, 0);
        chk("s4_still1", 64'(obs_busy[4]), 64'(1));
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 4, 4);
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        chk("s4_zero", 64'(obs_busy[4]), 64'(0));
        chk("s4_noerr", 64'(obs_err), 64'(0));

        // Underflow sets sticky error, reset clears it
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 9, 0);
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        chk("s5_error", 64'(obs_err), 64'(1));
        chk("s5_busy9", 64'(obs_busy[9]), 64'(0));
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        chk("s5_sticky", 64'(obs_err), 64'(1));
        do_reset();
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        chk("s5_cleared", 64'(obs_err), 64'(0));

        // Non-forwardable rewrite kills the forward tag
        do_issue(6, 0, 0, 0, 0, 1, 1);
        do_issue(6, 0, 0, 0, 0, 1, 0);
        do_read_retire(6, 2'b00, 0, 0);
        chk("s6_stall", 64'(obs_ready), 64'(0));
        chk("s6_nofwd", 64'(obs_f1), 64'(0));
        do_read_retire(6, 2'b01, 6, 0);
        do_read_retire(6, 2'b01, 6, 0);
        chk("s6_stall2", 64'(obs_ready), 64'(0));
        do_read_retire(6, 2'b00, 0, 0);
        chk("s6_ready", 64'(obs_ready), 64'(1));

        // Randomized traffic on a small register window to force collisions
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit [1:0] rv;
            rv[0] = ($urandom_range(0, 99) < 30);
            rv[1] = ($urandom_range(0, 99) < 20);
            run_cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70,
                      $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                      1'($urandom), 1'($urandom), $urandom_range(0, 99) < 80, 1'($urandom),
                      rv, $urandom_range(0, 7), $urandom_range(0, 7));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
